// File: rtl/ex_mul_unit.sv
// ex_mul_unit -- iterative shift-add multiplier for the EX stage.
//
// Latches the ID/EX operands when a multiply arrives, accumulates one
// multiplier bit per cycle into a 2*WIDTH product and stalls the upstream
// pipeline while working. The product, destination register and write
// enable are presented for a single cycle in DONE.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, signed_i     multiply request and operand signedness
//   data1_i, data2_i      multiplicand, multiplier
//   rd_i, RegWrite_i      destination register and write enable
//   flush_i               abort the current operation
//   stall_o, busy_o       pipeline freeze, FSM not idle
//   done_o                result valid this cycle
//   result_hi_o/_lo_o     upper/lower halves of the product
//   rd_o, RegWrite_o      latched destination, write enable gated by done_o
module ex_mul_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [4:0]       rd_i,
  input  logic             RegWrite_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic [4:0]       rd_o,
  output logic             RegWrite_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     mcand, mplier;
  logic [2*WIDTH-1:0]   acc, acc_nxt, prod;
  logic [CNT_W-1:0]     cnt;
  logic                 neg, rw_q, last, accept;
  logic [4:0]           rd_q;
  logic [WIDTH-1:0]     res_hi, res_lo;

  // Magnitude of a possibly signed operand; the most negative value maps to
  // itself, which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                               input logic sgn);
    logic signed [WIDTH-1:0] s;
    logic signed [WIDTH-1:0] n;
    s = $signed(v);
    n = -s;
    abs_val = (sgn && (s < 0)) ? $unsigned(n) : v;
  endfunction

  // Two's-complement of the product when the signs differed; carry dropped.
  function automatic logic [2*WIDTH-1:0] neg_prod(input logic [2*WIDTH-1:0] v,
                                                  input logic en);
    logic signed [2*WIDTH-1:0] s;
    logic signed [2*WIDTH-1:0] n;
    s = $signed(v);
    n = -s;
    neg_prod = en ? $unsigned(n) : v;
  endfunction

  assign last    = (cnt == CNT_W'(WIDTH-1));
  assign accept  = (state == IDLE) && start_i && !flush_i;
  assign acc_nxt = acc + (mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt)
                                    : {(2*WIDTH){1'b0}});
  assign prod    = neg_prod(acc_nxt, neg);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (flush_i) state_nxt = IDLE;
               else if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_o    = !rst_i && (accept || (state == RUN));
    busy_o     = (state != IDLE);
    done_o     = (state == DONE) && !flush_i;
    RegWrite_o = done_o && rw_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand capture on accept, one shift-add step per RUN cycle, and the
  // final (sign-corrected) product captured on the last RUN cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      rd_q   <= '0;
      rw_q   <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
    end else if (accept) begin
      mcand  <= abs_val(data1_i, signed_i);
      mplier <= abs_val(data2_i, signed_i);
      neg    <= signed_i && (data1_i[WIDTH-1] ^ data2_i[WIDTH-1]);
      rd_q   <= rd_i;
      rw_q   <= RegWrite_i;
      acc    <= '0;
      cnt    <= '0;
    end else if ((state == RUN) && !flush_i) begin
      acc    <= acc_nxt;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        res_hi <= prod[2*WIDTH-1:WIDTH];
        res_lo <= prod[WIDTH-1:0];
      end
    end
  end

  assign result_hi_o = res_hi;
  assign result_lo_o = res_lo;
  assign rd_o        = rd_q;

endmodule

// File: tb/tb_ex_mul_unit.sv
module tb_ex_mul_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, start, sgn, flush, rw;
  logic [W-1:0]  d1, d2;
  logic [4:0]    rd;
  logic          stall_o, busy_o, done_o, RegWrite_o;
  logic [W-1:0]  result_hi_o, result_lo_o;
  logic [4:0]    rd_o;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [4:0]   rd;
    logic         rw;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ex_mul_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .signed_i(sgn),
    .data1_i(d1), .data2_i(d2), .rd_i(rd), .RegWrite_i(rw),
    .flush_i(flush), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .result_hi_o(result_hi_o), .result_lo_o(result_lo_o),
    .rd_o(rd_o), .RegWrite_o(RegWrite_o)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic [4:0] r,
                                 input logic w);
    exp_t   e;
    longint sa, sb_;
    logic [63:0] p;
    if (s) begin
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      p   = 64'(sa * sb_);
    end else begin
      p = {32'h0, a} * {32'h0, b};
    end
    e.hi = p[63:32];
    e.lo = p[31:0];
    e.rd = r;
    e.rw = w;
    return e;
  endfunction

  // Issues one multiply and follows it until done_o or a cycle budget expires.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [4:0] r, input logic w,
                        output int stalls, output bit got,
                        output logic [W-1:0] hi, output logic [W-1:0] lo,
                        output logic [4:0] rdo, output logic rwo);
    @(negedge clk);
    start = 1'b1; d1 = a; d2 = b; sgn = s; rd = r; rw = w;
    stalls = 0; got = 1'b0; hi = '0; lo = '0; rdo = '0; rwo = 1'b0;
    for (int c = 0; c < 80 && !got; c++) begin
      #1;
      if (stall_o) stalls++;
      if (done_o) begin
        got = 1'b1; hi = result_hi_o; lo = result_lo_o;
        rdo = rd_o; rwo = RegWrite_o;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; flush = 1'b0; sgn = 1'b0;
    d1 = 32'd9; d2 = 32'd9; rd = 5'd1; rw = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%b want=0", stall_o);
    end
    checks++;
    if ({busy_o, done_o, RegWrite_o, result_hi_o, result_lo_o, rd_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b rw=%b hi=%h lo=%h rd=%0d want all 0",
               busy_o, done_o, RegWrite_o, result_hi_o, result_lo_o, rd_o);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ops(input bit signed_mode);
    logic [W-1:0] ta[6];
    logic [W-1:0] tb_[6];
    int           stalls;
    bit           got;
    logic [W-1:0] hi, lo;
    logic [4:0]   rdo;
    logic         rwo;
    exp_t         e;
    if (!signed_mode) begin
      ta  = '{32'd3, 32'hFFFFFFFF, 32'h00001234, 32'h0, $urandom, $urandom};
      tb_ = '{32'd5, 32'hFFFFFFFF, 32'h0, 32'h89ABCDEF, $urandom, $urandom};
    end else begin
      ta  = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd5, $urandom, $urandom};
      tb_ = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF7, $urandom, $urandom};
    end
    for (int i = 0; i < 6; i++) begin
      sb.push_back(model(ta[i], tb_[i], signed_mode, 5'(7 + i), (i != 1)));
      run_op(ta[i], tb_[i], signed_mode, 5'(7 + i), (i != 1),
             stalls, got, hi, lo, rdo, rwo);
      checks++;
      if (!got || sb.size() == 0) begin
        failures++; $display("FAIL op%0d_s%0d_done got=%b want=1", i, signed_mode, got);
        if (sb.size() != 0) void'(sb.pop_front());
      end else begin
        e = sb.pop_front();
        checks++;
        if ({hi, lo} !== {e.hi, e.lo}) begin
          failures++;
          $display("FAIL op%0d_s%0d_product got=%h_%h want=%h_%h", i, signed_mode, hi, lo, e.hi, e.lo);
        end
        checks++;
        if (rdo !== e.rd || rwo !== e.rw) begin
          failures++;
          $display("FAIL op%0d_s%0d_rd_rw got=%0d/%b want=%0d/%b", i, signed_mode, rdo, rwo, e.rd, e.rw);
        end
      end
      checks++;
      if (stalls != W + 1) begin
        failures++; $display("FAIL op%0d_s%0d_stall_len got=%0d want=%0d", i, signed_mode, stalls, W + 1);
      end
      #1;
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        failures++; $display("FAIL op%0d_s%0d_after_done got done=%b busy=%b want 0/0", i, signed_mode, done_o, busy_o);
      end
    end
  endtask

  task automatic test_back_to_back;
    int   dones = 0;
    int   stalls2 = 0;
    int   c;
    exp_t e;
    bit   second = 1'b0;
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; d1 = 32'd6; d2 = 32'd7; rd = 5'd20; rw = 1'b1;
    sb.push_back(model(32'd6, 32'd7, 1'b0, 5'd20, 1'b1));
    for (c = 0; c < 120 && dones < 2; c++) begin
      #1;
      if (second && stall_o) stalls2++;
      if (done_o) begin
        dones++;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL b2b_extra_done got=done want=none");
        end else begin
          e = sb.pop_front();
          if ({result_hi_o, result_lo_o, rd_o, RegWrite_o} !== {e.hi, e.lo, e.rd, e.rw}) begin
            failures++;
            $display("FAIL b2b_result%0d got=%h_%h rd=%0d rw=%b want=%h_%h rd=%0d rw=%b",
                     dones, result_hi_o, result_lo_o, rd_o, RegWrite_o, e.hi, e.lo, e.rd, e.rw);
          end
        end
        if (dones == 1) begin
          // start stays high: new operands appear while DONE is showing
          d1 = 32'd2; d2 = 32'd2; rd = 5'd21; second = 1'b1;
          sb.push_back(model(32'd2, 32'd2, 1'b0, 5'd21, 1'b1));
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (dones != 2) begin
      failures++; $display("FAIL b2b_done_count got=%0d want=2", dones);
    end
    checks++;
    if (stalls2 != W + 1) begin
      failures++; $display("FAIL b2b_second_stall got=%0d want=%0d", stalls2, W + 1);
    end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; d1 = 32'd11; d2 = 32'd13; rd = 5'd9; rw = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy_o, stall_o, done_o, RegWrite_o, result_hi_o, result_lo_o, rd_o} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got busy=%b stall=%b done=%b rw=%b hi=%h lo=%h rd=%0d want all 0",
               busy_o, stall_o, done_o, RegWrite_o, result_hi_o, result_lo_o, rd_o);
    end
    repeat (40) begin
      @(negedge clk); #1;
      if (done_o) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++; $display("FAIL rst_mid_no_done got=%0d want=0", dones);
    end
  endtask

  task automatic test_flush;
    int dones = 0;
    int rws = 0;
    @(negedge clk);
    start = 1'b1; sgn = 1'b1; d1 = 32'd100; d2 = 32'd3; rd = 5'd4; rw = 1'b1;
    repeat (5) @(negedge clk);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++; $display("FAIL flush_run_idle got busy=%b want=0", busy_o);
    end
    repeat (40) begin
      @(negedge clk); #1;
      if (done_o) dones++;
      if (RegWrite_o) rws++;
    end
    checks++;
    if (dones != 0 || rws != 0) begin
      failures++; $display("FAIL flush_run_no_done got done=%0d rw=%0d want 0/0", dones, rws);
    end
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      failures++; $display("FAIL flush_idle_stall got=%b want=0", stall_o);
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++; $display("FAIL flush_idle_start got busy=%b want=0", busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_ops(1'b0);
    test_ops(1'b1);
    test_back_to_back();
    test_reset_mid();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mul_unit.md
# ex_mul_unit

Iterative 32x32 multiplier in the EX stage, driven directly by the ID/EX pipeline register outputs. When a multiply instruction arrives it latches the operands and computes a 64-bit product at one bit per cycle. While it works, it asserts `stall_o` so the PC, IF/ID and ID/EX registers hold. It then presents the product, destination register and write-enable for one cycle and releases the pipeline.

## Interface
- `WIDTH`, default 32: operand width; product is 2*WIDTH bits.
- `CNT_W`, default 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  EX holds a multiply instruction; stays high while the instruction is held by stall.
- `signed_i`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `start_i`.
- `data1_i`  in  WIDTH  multiplicand (ID/EX data1).
- `data2_i`  in  WIDTH  multiplier (ID/EX data2).
- `rd_i`  in  5  destination register.
- `RegWrite_i`  in  1  write-enable of the instruction.
- `flush_i`  in  1  abort the current operation.
- `stall_o`  out  1  freeze the upstream pipeline.
- `busy_o`  out  1  FSM not in IDLE.
- `done_o`  out  1  result valid this cycle.
- `result_hi_o`  out  WIDTH  product bits [2*WIDTH-1:WIDTH].
- `result_lo_o`  out  WIDTH  product bits [WIDTH-1:0].
- `rd_o`  out  5  latched destination.
- `RegWrite_o`  out  1  latched write-enable, gated by `done_o`.

## Operation
The FSM has three states: IDLE, RUN, DONE.

- **IDLE, `start_i`=1:**
  - latch |data1|, |data2| (absolute value if `signed_i`, else raw);
  - latch the negate flag = `signed_i` & (data1[MSB] ^ data2[MSB]);
  - latch `rd_i` and `RegWrite_i`;
  - clear the 2*WIDTH accumulator; counter = 0; go to RUN.
- **RUN, each cycle:**
  - if multiplier LSB = 1, accumulator += multiplicand shifted left by the counter value;
  - shift the multiplier right by 1; counter += 1;
  - when the counter reaches WIDTH-1 on this cycle, go to DONE.
  - Equivalent shift-add formulations are allowed if cycle counts match.
- **Entry to DONE:** if the negate flag is set, the result registers take the two's-complement of the accumulator (sum computed as 2*WIDTH bits, carry discarded).
- **DONE:** `done_o`=1, `stall_o`=0, `RegWrite_o` = latched value. Always go to IDLE next cycle. `start_i` is ignored in DONE, because it still reflects the instruction now leaving EX.
- **Absolute value of 0x80000000:** equals 0x80000000 treated as unsigned; no overflow handling needed.
- **`flush_i`=1 in RUN or DONE:** go to IDLE next edge. No `done_o` is issued, and `RegWrite_o` stays 0.
- **`flush_i` and `start_i` both high in IDLE:** flush wins; the operation does not start.
- **`rst_i`:** overrides everything including flush.

Output rules:
- `stall_o` = (IDLE & `start_i` & !`flush_i`) | RUN. It is combinational so the first EX cycle already stalls.
- `result_*_o` and `rd_o` hold their last values outside DONE.
- `done_o` and `RegWrite_o` are 0 outside DONE.

## Timing
- **Reset values (cycle after `rst_i` sampled high):** state IDLE; `busy_o`, `done_o`, `RegWrite_o`, `result_hi_o`, `result_lo_o`, `rd_o`, accumulator and counter all 0.
- **`stall_o` under reset:** 0 while `rst_i` is high, regardless of `start_i`.
- **Start-to-done timing:** if `start_i` is seen at edge E0, RUN occupies cycles E0+1 to E0+WIDTH, and DONE is cycle E0+WIDTH+1.
- **Stall length:** `stall_o` is high for WIDTH+1 consecutive cycles (33 at default).
- **Back-to-back multiplies:** the earliest next start is sampled in the IDLE cycle after DONE. The minimum issue interval is WIDTH+2 cycles.
- **Reset mid-RUN:** IDLE at the next edge; no `done_o` for the aborted operation.

## Test plan
- **Unsigned small:** `signed_i`=0, 3 x 5, `rd_i`=7, `RegWrite_i`=1 -> `stall_o` high for 33 cycles; then `done_o`=1 for one cycle with hi=0x00000000, lo=0x0000000F, `rd_o`=7, `RegWrite_o`=1.
- **Unsigned max:** 0xFFFFFFFF x 0xFFFFFFFF, unsigned -> hi=0xFFFFFFFE, lo=0x00000001.
- **Signed mixed and corner cases:**
  - -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB;
  - 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000;
  - -1 x -1 -> hi=0, lo=1.
- **Held start:** `start_i` kept high through DONE and for one further cycle, with new operands 2 x 2 -> first result completes once, then IDLE sees `start_i` and starts a new operation; second `done_o` after another 33 stall cycles with lo=4.
- **Reset mid-operation:** `rst_i` pulsed at RUN cycle 10 -> next cycle `busy_o`=0, `stall_o`=0, all outputs 0; `done_o` never asserts for that operation.
- **Flush:** `flush_i` at RUN cycle 5 -> IDLE next edge; no `done_o`; `RegWrite_o` stays 0. `flush_i` together with `start_i` in IDLE -> `stall_o`=0, no start.
